// File: rtl/cpu_memory.sv
// Memory stage: runs loads, stores and cache flushes over a simple request/ready bus.
// Optional define CPU_MEMORY_ALIGN_FAULT_EN turns misaligned accesses into a sticky fault instead of masking the address.
package cpu_memory_pkg;
  typedef struct packed {
    logic [3:0]  tag;
    logic [4:0]  inst_rd;
    logic [31:0] rd;
    logic        mem_read;
    logic        mem_write;
    logic        mem_flush;
    logic [2:0]  mem_width;   // access size in bytes: 1, 2 or 4
    logic        mem_signed;
    logic [31:0] mem_address;
    logic [4:0]  mem_inst_rd;
  } execute_data_t;

  typedef struct packed {
    logic [3:0]  tag;
    logic [4:0]  inst_rd;
    logic [31:0] rd;
  } memory_data_t;
endpackage

module cpu_memory
  import cpu_memory_pkg::*;
(
  input  logic          i_clock,
  input  logic          i_reset,
  input  execute_data_t i_data,
  output logic          o_busy,
  output logic          o_bus_request,
  output logic          o_bus_rw,
  output logic [31:0]   o_bus_address,
  output logic [31:0]   o_bus_wdata,
  output logic [3:0]    o_bus_byte_enable,
  input  logic          i_bus_ready,
  input  logic [31:0]   i_bus_rdata,
  output logic          o_flush_request,
  input  logic          i_flush_ready,
  output logic          o_fault,
  output memory_data_t  o_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FLUSH} state_t;

  state_t      state, state_next;
  logic        is_mem, new_op, accept, align_fault;
  logic        bus_done, flush_done;
  logic [1:0]  lane;
  logic [3:0]  lane_mask;
  logic [31:0] shifted, load_value, store_data;

  always_comb begin
    is_mem = i_data.mem_read | i_data.mem_write | i_data.mem_flush;
    new_op = (i_data.tag != o_data.tag);
    accept = new_op && (state == IDLE);
`ifdef CPU_MEMORY_ALIGN_FAULT_EN
    align_fault = (i_data.mem_read || i_data.mem_write) &&
                  (((i_data.mem_width == 3'd2) && i_data.mem_address[0]) ||
                   ((i_data.mem_width == 3'd4) && (i_data.mem_address[1:0] != 2'b00)));
`else
    align_fault = 1'b0;
`endif
    // Byte lane forced to the natural alignment of the access size.
    if (i_data.mem_width == 3'd1)      lane = i_data.mem_address[1:0];
    else if (i_data.mem_width == 3'd2) lane = {i_data.mem_address[1], 1'b0};
    else                               lane = 2'b00;

    if (i_data.mem_width == 3'd1) begin
      lane_mask  = 4'b0001 << lane;
      store_data = {4{i_data.rd[7:0]}};
    end else if (i_data.mem_width == 3'd2) begin
      lane_mask  = 4'b0011 << lane;
      store_data = {2{i_data.rd[15:0]}};
    end else begin
      lane_mask  = 4'b1111;
      store_data = i_data.rd;
    end

    shifted = i_bus_rdata >> {lane, 3'b000};
    if (i_data.mem_width == 3'd1)
      load_value = {{24{i_data.mem_signed & shifted[7]}}, shifted[7:0]};
    else if (i_data.mem_width == 3'd2)
      load_value = {{16{i_data.mem_signed & shifted[15]}}, shifted[15:0]};
    else
      load_value = shifted;

    bus_done   = ((state == READ) || (state == WRITE)) && o_bus_request && i_bus_ready;
    flush_done = (state == FLUSH) && i_flush_ready;
    o_busy     = (state != IDLE) || (new_op && is_mem);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !align_fault) begin
          if (i_data.mem_read)       state_next = READ;
          else if (i_data.mem_write) state_next = WRITE;
          else if (i_data.mem_flush) state_next = FLUSH;
        end
      end
      READ, WRITE: if (bus_done)   state_next = IDLE;
      FLUSH:       if (flush_done) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_bus_request     <= 1'b0;
      o_bus_rw          <= 1'b0;
      o_bus_address     <= '0;
      o_bus_wdata       <= '0;
      o_bus_byte_enable <= '0;
      o_flush_request   <= 1'b0;
      o_fault           <= 1'b0;
      o_data            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (align_fault) begin
              o_fault        <= 1'b1;
              o_data.tag     <= i_data.tag;
              o_data.inst_rd <= i_data.mem_read ? i_data.mem_inst_rd : 5'd0;
              o_data.rd      <= '0;
            end else if (i_data.mem_read || i_data.mem_write) begin
              o_bus_request     <= 1'b1;
              o_bus_rw          <= ~i_data.mem_read;
              o_bus_address     <= {i_data.mem_address[31:2], 2'b00};
              o_bus_byte_enable <= lane_mask;
              o_bus_wdata       <= i_data.mem_read ? 32'd0 : store_data;
            end else if (i_data.mem_flush) begin
              o_flush_request <= 1'b1;
            end else begin
              o_data.tag     <= i_data.tag;
              o_data.inst_rd <= i_data.inst_rd;
              o_data.rd      <= i_data.rd;
            end
          end
        end
        READ: begin
          if (bus_done) begin
            o_bus_request  <= 1'b0;
            o_data.tag     <= i_data.tag;
            o_data.inst_rd <= i_data.mem_inst_rd;
            o_data.rd      <= load_value;
          end
        end
        WRITE: begin
          if (bus_done) begin
            o_bus_request  <= 1'b0;
            o_data.tag     <= i_data.tag;
            o_data.inst_rd <= 5'd0;
          end
        end
        FLUSH: begin
          if (flush_done) begin
            o_flush_request <= 1'b0;
            o_data.tag      <= i_data.tag;
            o_data.inst_rd  <= 5'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_memory.sv
// Scoreboard bench for cpu_memory: expected bus transfers and results are queued at issue
// and popped by a negedge monitor whenever a transfer completes or o_data's tag moves.
module tb_cpu_memory;
  import cpu_memory_pkg::*;

  logic          clk = 1'b0;
  logic          i_reset;
  execute_data_t i_data;
  logic          o_busy, o_bus_request, o_bus_rw, i_bus_ready, o_flush_request, i_flush_ready, o_fault;
  logic [31:0]   o_bus_address, o_bus_wdata, i_bus_rdata;
  logic [3:0]    o_bus_byte_enable;
  memory_data_t  o_data;

  typedef struct packed {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_exp_t;

  memory_data_t exp_q[$];
  bus_exp_t     bus_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [3:0]   prev_tag = '0;

  cpu_memory dut (
    .i_clock(clk), .i_reset(i_reset), .i_data(i_data), .o_busy(o_busy),
    .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw), .o_bus_address(o_bus_address),
    .o_bus_wdata(o_bus_wdata), .o_bus_byte_enable(o_bus_byte_enable),
    .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata),
    .o_flush_request(o_flush_request), .i_flush_ready(i_flush_ready),
    .o_fault(o_fault), .o_data(o_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_bus_request && i_bus_ready) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected addr=%h", o_bus_address);
        end else begin
          bus_exp_t b;
          b = bus_q.pop_front();
          check("bus_addr", 64'(o_bus_address), 64'(b.addr));
          check("bus_rw", 64'(o_bus_rw), 64'(b.rw));
          check("bus_wdata", 64'(o_bus_wdata), 64'(b.wdata));
          check("bus_be", 64'(o_bus_byte_enable), 64'(b.be));
        end
      end
      if (o_data.tag !== prev_tag) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL data_unexpected actual=%h", o_data);
        end else begin
          memory_data_t e;
          e = exp_q.pop_front();
          check("o_data", 64'(o_data), 64'(e));
        end
      end
    end
    prev_tag = o_data.tag;
  end

  function automatic execute_data_t mk(input logic [3:0] tag, input logic [31:0] rd,
      input logic [4:0] inst_rd, input logic r, input logic w, input logic f,
      input logic [2:0] width, input logic sgn, input logic [31:0] addr, input logic [4:0] minst);
    execute_data_t d;
    d.tag = tag; d.rd = rd; d.inst_rd = inst_rd;
    d.mem_read = r; d.mem_write = w; d.mem_flush = f;
    d.mem_width = width; d.mem_signed = sgn; d.mem_address = addr; d.mem_inst_rd = minst;
    return d;
  endfunction

  // Called at posedge+1; ready is raised on the wait_n-th request cycle.
  task automatic run_op(input execute_data_t d, input logic [31:0] rdata, input int wait_n,
                        output int busy_n, output int req_n);
    int cyc;
    busy_n = 0; req_n = 0; cyc = 0;
    i_bus_rdata = rdata;
    i_data = d;
    while (cyc < 60) begin
      #2;
      if (o_bus_request || o_flush_request) begin
        req_n++;
        if (req_n >= wait_n) begin
          if (o_bus_request) i_bus_ready = 1'b1;
          else               i_flush_ready = 1'b1;
        end
      end
      if (!o_busy) break;
      busy_n++;
      @(posedge clk); #1;
      i_bus_ready = 1'b0; i_flush_ready = 1'b0;
      cyc++;
    end
    if (cyc >= 60) begin
      checks++; errors++;
      $display("FAIL op_timeout tag=%0d busy_cycles=%0d", d.tag, busy_n);
    end
    @(posedge clk); #1;
  endtask

  int busy_n, req_n;

  initial begin
    i_reset = 1'b1; i_bus_ready = 1'b0; i_flush_ready = 1'b0; i_bus_rdata = '0; i_data = '0;
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
    #2;
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_req", 64'(o_bus_request), 64'd0);
    check("rst_addr", 64'(o_bus_address), 64'd0);
    check("rst_wdata", 64'(o_bus_wdata), 64'd0);
    check("rst_be", 64'(o_bus_byte_enable), 64'd0);
    check("rst_flush", 64'(o_flush_request), 64'd0);
    check("rst_fault", 64'(o_fault), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    @(posedge clk); #1;

    // ALU op
    exp_q.push_back('{4'd1, 5'd5, 32'h1234});
    run_op(mk(4'd1, 32'h1234, 5'd5, 0, 0, 0, 3'd4, 0, 32'h0, 5'd0), 32'h0, 1, busy_n, req_n);
    check("alu_busy", 64'(busy_n), 64'd0);
    check("alu_req", 64'(req_n), 64'd0);

    // Signed byte read, ready on 3rd request cycle
    bus_q.push_back('{32'h100, 1'b0, 32'h0, 4'b1000});
    exp_q.push_back('{4'd2, 5'd7, 32'hFFFFFF80});
    run_op(mk(4'd2, 32'h0, 5'd0, 1, 0, 0, 3'd1, 1, 32'h103, 5'd7), 32'h80FFFFFF, 3, busy_n, req_n);
    check("sbyte_busy", 64'(busy_n), 64'd4);

    // Halfword write, zero wait
    bus_q.push_back('{32'h200, 1'b1, 32'hBEEFBEEF, 4'b1100});
    exp_q.push_back('{4'd3, 5'd0, 32'hFFFFFF80});
    run_op(mk(4'd3, 32'h0000BEEF, 5'd0, 0, 1, 0, 3'd2, 0, 32'h202, 5'd8), 32'h0, 1, busy_n, req_n);
    check("hw_write_busy", 64'(busy_n), 64'd2);

    // Unsigned halfword read, upper lane
    bus_q.push_back('{32'h300, 1'b0, 32'h0, 4'b1100});
    exp_q.push_back('{4'd4, 5'd9, 32'h0000A5A5});
    run_op(mk(4'd4, 32'h0, 5'd0, 1, 0, 0, 3'd2, 0, 32'h302, 5'd9), 32'hA5A51234, 2, busy_n, req_n);
    check("uhw_busy", 64'(busy_n), 64'd3);

    // Word write
    bus_q.push_back('{32'h40C, 1'b1, 32'hDEADBEEF, 4'b1111});
    exp_q.push_back('{4'd5, 5'd0, 32'h0000A5A5});
    run_op(mk(4'd5, 32'hDEADBEEF, 5'd0, 0, 1, 0, 3'd4, 0, 32'h40C, 5'd0), 32'h0, 1, busy_n, req_n);

    // Byte write, lane 1
    bus_q.push_back('{32'h500, 1'b1, 32'h78787878, 4'b0010});
    exp_q.push_back('{4'd6, 5'd0, 32'h0000A5A5});
    run_op(mk(4'd6, 32'h12345678, 5'd0, 0, 1, 0, 3'd1, 0, 32'h501, 5'd0), 32'h0, 2, busy_n, req_n);

    // Misaligned word read
`ifdef CPU_MEMORY_ALIGN_FAULT_EN
    exp_q.push_back('{4'd7, 5'd3, 32'h0});
    run_op(mk(4'd7, 32'h0, 5'd0, 1, 0, 0, 3'd4, 0, 32'h2, 5'd3), 32'h11223344, 1, busy_n, req_n);
    check("mis_req", 64'(req_n), 64'd0);
    check("mis_fault", 64'(o_fault), 64'd1);
`else
    bus_q.push_back('{32'h0, 1'b0, 32'h0, 4'b1111});
    exp_q.push_back('{4'd7, 5'd3, 32'h11223344});
    run_op(mk(4'd7, 32'h0, 5'd0, 1, 0, 0, 3'd4, 0, 32'h2, 5'd3), 32'h11223344, 1, busy_n, req_n);
    check("mis_req", 64'(req_n), 64'd1);
    check("mis_fault", 64'(o_fault), 64'd0);
`endif

    // Signed halfword read
    bus_q.push_back('{32'h4, 1'b0, 32'h0, 4'b1100});
    exp_q.push_back('{4'd8, 5'd4, 32'hFFFF8001});
    run_op(mk(4'd8, 32'h0, 5'd0, 1, 0, 0, 3'd2, 1, 32'h6, 5'd4), 32'h80010000, 1, busy_n, req_n);

    // Flush, ready after 5 request cycles
    exp_q.push_back('{4'd9, 5'd0, 32'hFFFF8001});
    run_op(mk(4'd9, 32'h0, 5'd0, 0, 0, 1, 3'd4, 0, 32'h0, 5'd6), 32'h0, 5, busy_n, req_n);
    check("flush_req_cycles", 64'(req_n), 64'd5);
    check("flush_busy", 64'(busy_n), 64'd6);

    // All three mem flags: read wins
    bus_q.push_back('{32'h10, 1'b0, 32'h0, 4'b1111});
    exp_q.push_back('{4'd10, 5'd2, 32'hCAFEF00D});
    run_op(mk(4'd10, 32'h0, 5'd0, 1, 1, 1, 3'd4, 0, 32'h10, 5'd2), 32'hCAFEF00D, 1, busy_n, req_n);

    // Same tag held, stray bus ready while idle: nothing may happen
    i_bus_ready = 1'b1;
    repeat (2) begin
      #2;
      check("idle_busy", 64'(o_busy), 64'd0);
      check("idle_req", 64'(o_bus_request), 64'd0);
      @(posedge clk); #1;
    end
    i_bus_ready = 1'b0;

    // Reset during READ with ready on the same edge
    i_data = mk(4'd11, 32'h0, 5'd0, 1, 0, 0, 3'd4, 0, 32'h20, 5'd1);
    @(posedge clk); #1;
    check("pre_rst_req", 64'(o_bus_request), 64'd1);
    i_reset = 1'b1; i_bus_ready = 1'b1; i_bus_rdata = 32'h55555555;
    @(posedge clk); #1;
    check("rst_mid_req", 64'(o_bus_request), 64'd0);
    check("rst_mid_data", 64'(o_data), 64'd0);
    i_data = '0; i_bus_ready = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_data", 64'(o_data), 64'd0);
    check("post_rst_fault", 64'(o_fault), 64'd0);

    repeat (2) @(posedge clk);
    #1;
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("bus_q_empty", 64'(bus_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_memory.md
CPU_MEMORY -- requirements
Module: CPU_Memory

Interface
REQ-001 SHALL have i_clock, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have i_reset, input, 1, synchronous active-high reset sampled on rising i_clock.
REQ-003 SHALL have i_data, input, execute_data_t: tag, inst_rd, rd, mem_read, mem_write, mem_flush, mem_width, mem_signed, mem_address, mem_inst_rd.
REQ-004 SHALL have o_busy, output, 1, stall to execute stage; i_data held stable while high.
REQ-005 SHALL have o_bus_request, output, 1; o_bus_rw, output, 1 (1=write); o_bus_address, output, 32; o_bus_wdata, output, 32; o_bus_byte_enable, output, 4.
REQ-006 SHALL have i_bus_ready, input, 1; i_bus_rdata, input, 32.
REQ-007 SHALL have o_flush_request, output, 1; i_flush_ready, input, 1 (data cache flush handshake).
REQ-008 SHALL have o_fault, output, 1, sticky misaligned-access fault (see Configuration).
REQ-009 SHALL have o_data, output, memory_data_t: tag, inst_rd, rd; registered.

Function
REQ-010 New operation SHALL be accepted when i_data.tag != o_data.tag and state is IDLE.
REQ-011 States SHALL be IDLE, READ, WRITE, FLUSH; IDLE->READ on mem_read, ->WRITE on mem_write, ->FLUSH on mem_flush (priority read > write > flush); return to IDLE on handshake completion.
REQ-012 Non-memory op SHALL complete in 1 cycle: o_data.rd <= i_data.rd, o_data.inst_rd <= i_data.inst_rd, o_data.tag <= i_data.tag.
REQ-013 Bus access SHALL drive o_bus_address = {mem_address[31:2], 2'b00}; request, address, rw, wdata, byte_enable stable from entry until the cycle i_bus_ready is sampled high.
REQ-014 Transfer completes on the first rising edge with o_bus_request && i_bus_ready; o_bus_request SHALL deassert the following cycle; no back-to-back request without passing through IDLE.
REQ-015 Read result SHALL be i_bus_rdata shifted right by 8*address[1:0], then width 1/2/4 bytes extended (sign if mem_signed, else zero); written to o_data.rd with o_data.inst_rd <= mem_inst_rd and tag update on completion edge.
REQ-016 Write SHALL take data from i_data.rd: width 1 replicates byte to all lanes, byte_enable = 0001<<addr[1:0]; width 2 replicates halfword, byte_enable = 0011<<addr[1]*2; width 4 byte_enable = 1111; completion sets o_data.inst_rd = 0, tag updated.
REQ-017 Flush SHALL hold o_flush_request until i_flush_ready high; completion updates tag, inst_rd = 0.
REQ-018 o_busy SHALL be combinational: high when state != IDLE, or new tag with any mem_* set; low in the completion cycle's next edge only (i.e. low once state returns IDLE).
REQ-019 Minimum latency: read/write/flush = 1 cycle issue + bus wait; zero-wait bus (ready on first request cycle) SHALL complete in 2 cycles from acceptance.
REQ-020 i_bus_ready high while o_bus_request low SHALL be ignored.

Reset
REQ-021 On i_reset: state IDLE, o_bus_request 0, o_bus_rw 0, o_bus_address 0, o_bus_wdata 0, o_bus_byte_enable 0, o_flush_request 0, o_fault 0, o_data 0 (tag 0).
REQ-022 Reset mid-transfer SHALL drop request next edge regardless of i_bus_ready; partial transfer discarded, no o_data update.

Configuration
REQ-023 Macro CPU_MEMORY_ALIGN_FAULT_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL set o_fault, issue no bus cycle, complete op with rd=0 in 1 cycle.
REQ-024 Macro undefined: misaligned low bits SHALL be masked to width alignment (halfword addr[0]=0, word addr[1:0]=0) and access proceeds; o_fault stays 0.

Verification
REQ-025 ALU op tag 1, rd=0x1234, inst_rd=5 -> next cycle o_data={tag1, rd 0x1234, inst_rd 5}, no bus request.
REQ-026 Signed byte read addr 0x103, rdata 0x80FFFFFF, ready after 3 cycles -> o_data.rd 0xFFFFFF80, address 0x100, busy high 4 cycles.
REQ-027 Halfword write addr 0x202, rd 0x0000BEEF, zero-wait -> wdata 0xBEEFBEEF, byte_enable 1100, rw 1, completes in 2 cycles.
REQ-028 Reset asserted in READ with i_bus_ready high same edge -> o_data stays 0, request low next cycle.
REQ-029 Word read addr 0x2 with CPU_MEMORY_ALIGN_FAULT_EN -> o_fault 1, no request; without macro -> request address 0x0.
REQ-030 Flush, i_flush_ready after 5 cycles -> o_flush_request high 5 cycles, tag updated, inst_rd 0.
